// File: rtl/dm_sb_engine.sv
// System bus access engine: turns sbaddress/sbdata CSR accesses into single req/gnt/r_valid
// bus transactions and reports read data, busy and sberror back to the CSR layer.
module dm_sb_engine #(
   parameter int unsigned BusWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  dmactive_i,
   input  logic [BusWidth-1:0]   sbaddress_i,
   input  logic                  sbaddress_write_valid_i,
   input  logic                  sbreadonaddr_i,
   input  logic                  sbautoincrement_i,
   input  logic [2:0]            sbaccess_i,
   input  logic                  sbreadondata_i,
   input  logic [BusWidth-1:0]   sbdata_i,
   input  logic                  sbdata_read_valid_i,
   input  logic                  sbdata_write_valid_i,
   output logic [BusWidth-1:0]   sbaddress_o,
   output logic [BusWidth-1:0]   sbdata_o,
   output logic                  sbdata_valid_o,
   output logic                  sbbusy_o,
   output logic                  sberror_valid_o,
   output logic [2:0]            sberror_o,
   output logic                  master_req_o,
   output logic [BusWidth-1:0]   master_add_o,
   output logic                  master_we_o,
   output logic [BusWidth-1:0]   master_wdata_o,
   output logic [BusWidth/8-1:0] master_be_o,
   input  logic                  master_gnt_i,
   input  logic                  master_r_valid_i,
   input  logic [BusWidth-1:0]   master_r_rdata_i,
   input  logic                  master_r_err_i
);

   localparam int unsigned BeW  = BusWidth / 8;
   localparam int unsigned OffW = $clog2(BeW);

   typedef enum logic [2:0] {
      StIdle, StRead, StWrite, StWaitRead, StWaitWrite
   } sba_state_e;

   sba_state_e          state_q, state_d;
   logic [BusWidth-1:0] addr_q, addr_d;
   logic [BusWidth-1:0] rdata_q, rdata_d;
   logic [BusWidth-1:0] wdata_q, wdata_d;
   logic [1:0]          size_q, size_d;
   logic [2:0]          err_q, err_d;
   logic                err_valid_q, err_valid_d;
   logic                rvalid_q, rvalid_d;
   logic                abort_q, abort_d;

   logic [BusWidth-1:0] eff_addr, align_mask, rdata_shift, rdata_mask;
   logic [OffW-1:0]     offset;
   logic [BeW-1:0]      be_base;
   logic                trig_write, trig_read, size_err, misaligned, discard;

   assign offset      = addr_q[OffW-1:0];
   assign rdata_shift = master_r_rdata_i >> {offset, 3'b000};

   always_comb begin
      be_base    = '0;
      rdata_mask = '0;
      for (int unsigned i = 0; i < BeW; i++) begin
         be_base[i]          = (i < (32'd1 << size_q));
         rdata_mask[8*i +: 8] = {8{be_base[i]}};
      end
   end

   // Trigger checks use the address being loaded this cycle, if any.
   assign eff_addr   = (state_q == StIdle && sbaddress_write_valid_i) ? sbaddress_i : addr_q;
   assign size_err   = 32'(sbaccess_i) > OffW;
   assign align_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
   assign misaligned = |(eff_addr & align_mask);
   assign trig_write = dmactive_i && sbdata_write_valid_i;
   assign trig_read  = dmactive_i && !sbdata_write_valid_i &&
                       ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                        (sbdata_read_valid_i && sbreadondata_i));
   assign discard    = abort_q || !dmactive_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      err_d       = err_q;
      err_valid_d = 1'b0;
      rvalid_d    = 1'b0;
      abort_d     = abort_q;
      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            if (sbaddress_write_valid_i) addr_d = sbaddress_i;
            if (trig_write || trig_read) begin
               if (size_err) begin
                  err_d       = 3'd4;
                  err_valid_d = 1'b1;
               end else if (misaligned) begin
                  err_d       = 3'd3;
                  err_valid_d = 1'b1;
               end else begin
                  state_d = trig_write ? StWrite : StRead;
                  wdata_d = sbdata_i;
                  size_d  = sbaccess_i[1:0];
               end
            end
         end
         StRead, StWrite: begin
            if (master_gnt_i) begin
               state_d = (state_q == StRead) ? StWaitRead : StWaitWrite;
               abort_d = !dmactive_i;
            end else if (!dmactive_i) begin
               state_d = StIdle;
            end
         end
         StWaitRead, StWaitWrite: begin
            if (!dmactive_i) abort_d = 1'b1;
            if (master_r_valid_i) begin
               state_d = StIdle;
               abort_d = 1'b0;
               if (!discard) begin
                  if (master_r_err_i) begin
                     err_d       = 3'd7;
                     err_valid_d = 1'b1;
                  end else begin
                     if (state_q == StWaitRead) begin
                        rdata_d  = rdata_shift & rdata_mask;
                        rvalid_d = 1'b1;
                     end
                     if (sbautoincrement_i) addr_d = addr_q + (BusWidth'(1) << size_q);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
         rvalid_q    <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         rvalid_q    <= rvalid_d;
         abort_q     <= abort_d;
      end
   end

   assign master_req_o    = (state_q == StRead) || (state_q == StWrite);
   assign master_we_o     = (state_q == StWrite);
   assign master_add_o    = addr_q;
   assign master_be_o     = master_req_o ? BeW'(be_base << offset) : '0;
   assign master_wdata_o  = master_we_o ? (wdata_q << {offset, 3'b000}) : '0;
   assign sbaddress_o     = addr_q;
   assign sbdata_o        = rdata_q;
   assign sbdata_valid_o  = rvalid_q;
   assign sbbusy_o        = (state_q != StIdle);
   assign sberror_valid_o = err_valid_q;
   assign sberror_o       = err_q;

endmodule
